// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage data-port controller for the RV32I pipeline.
// Issues one data-memory access per load/store, stalls the pipeline until the
// memory responds, and returns the lane-extracted, extended load result.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  offset_q, offset_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_write_q, is_write_d;
    logic        dmem_read_q, dmem_read_d;
    logic        dmem_write_q, dmem_write_d;
    logic [31:0] dmem_address_q, dmem_address_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_byte_enable_q, dmem_byte_enable_d;
    logic [31:0] load_data_q, load_data_d;

    logic        req;
    logic        bad_fields;
    logic        access_error;
    logic        legal_req;
    logic [31:0] shifted;
    logic [31:0] extracted;

    // Classify the incoming request: legal access, illegal access, or nothing.
    always_comb begin
        req        = req_valid & (mem_read ^ mem_write);
        bad_fields = 1'b0;
        if (mem_read) begin
            case (funct3)
                3'b000, 3'b100: bad_fields = 1'b0;
                3'b001, 3'b101: bad_fields = addr[0];
                3'b010:         bad_fields = |addr[1:0];
                default:        bad_fields = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000:  bad_fields = 1'b0;
                3'b001:  bad_fields = addr[0];
                3'b010:  bad_fields = |addr[1:0];
                default: bad_fields = 1'b1;
            endcase
        end
        access_error = (req_valid & mem_read & mem_write) | (req & bad_fields);
        legal_req    = req & ~bad_fields;
    end

    // Pull the addressed lane down to bit 0 and extend it by load type.
    always_comb begin
        shifted = dmem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  extracted = {24'b0, shifted[7:0]};
            3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  extracted = {16'b0, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    // State register plus the latched request and registered memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            offset_q           <= 2'b0;
            funct3_q           <= 3'b0;
            is_write_q         <= 1'b0;
            dmem_read_q        <= 1'b0;
            dmem_write_q       <= 1'b0;
            dmem_address_q     <= 32'b0;
            dmem_wdata_q       <= 32'b0;
            dmem_byte_enable_q <= 4'b0;
            load_data_q        <= 32'b0;
        end else begin
            state_q            <= state_d;
            offset_q           <= offset_d;
            funct3_q           <= funct3_d;
            is_write_q         <= is_write_d;
            dmem_read_q        <= dmem_read_d;
            dmem_write_q       <= dmem_write_d;
            dmem_address_q     <= dmem_address_d;
            dmem_wdata_q       <= dmem_wdata_d;
            dmem_byte_enable_q <= dmem_byte_enable_d;
            load_data_q        <= load_data_d;
        end
    end

    // Next state: launch on a legal request, wait for the response, then retire.
    always_comb begin
        state_d            = state_q;
        offset_d           = offset_q;
        funct3_d           = funct3_q;
        is_write_d         = is_write_q;
        dmem_read_d        = dmem_read_q;
        dmem_write_d       = dmem_write_q;
        dmem_address_d     = dmem_address_q;
        dmem_wdata_d       = dmem_wdata_q;
        dmem_byte_enable_d = dmem_byte_enable_q;
        load_data_d        = load_data_q;
        case (state_q)
            IDLE: begin
                if (legal_req) begin
                    state_d        = ACCESS;
                    offset_d       = addr[1:0];
                    funct3_d       = funct3;
                    is_write_d     = mem_write;
                    dmem_read_d    = mem_read;
                    dmem_write_d   = mem_write;
                    dmem_address_d = {addr[31:2], 2'b00};
                    dmem_wdata_d   = store_data << {addr[1:0], 3'b000};
                    if (mem_write) begin
                        case (funct3[1:0])
                            2'b00:   dmem_byte_enable_d = 4'b0001 << addr[1:0];
                            2'b01:   dmem_byte_enable_d = 4'b0011 << addr[1:0];
                            default: dmem_byte_enable_d = 4'b1111;
                        endcase
                    end else begin
                        dmem_byte_enable_d = 4'b1111;
                    end
                end
            end
            ACCESS: begin
                if (dmem_resp) begin
                    state_d      = DONE;
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    if (!is_write_q) begin
                        load_data_d = extracted;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: stall covers the request cycle and every ACCESS cycle.
    always_comb begin
        stall      = ((state_q == IDLE) & legal_req) | (state_q == ACCESS);
        misaligned = (state_q == IDLE) & access_error;
        load_valid = (state_q == DONE) & ~is_write_q;
    end

    assign load_data        = load_data_q;
    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_address     = dmem_address_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign dmem_byte_enable = dmem_byte_enable_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory-stage data-port controller.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    int compared   = 0;
    int mismatched = 0;

    mem_access_unit dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .stall            (stall),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .misaligned       (misaligned),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive the EX/MEM-side request fields.
    task automatic applyStimulus(input logic rv, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd);
        req_valid  = rv;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    // One full memory access; the response arrives at cycle resp_cycle.
    task automatic doAccess(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rdata,
                            input int resp_cycle, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] wmask, input logic [31:0] exp_load,
                            input int exp_stall);
        int   stall_cycles;
        int   done_cycle;
        logic done;
        stall_cycles = 1;
        done_cycle   = 0;
        done         = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, rd, wr, f3, a, sd);
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h5555_5555;
        #1;
        checkOutput({tag, "_c0_stall"}, 32'(stall), 32'd1);
        checkOutput({tag, "_c0_strobe"}, 32'({dmem_read, dmem_write}), 32'd0);
        checkOutput({tag, "_c0_misaligned"}, 32'(misaligned), 32'd0);
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (c == resp_cycle) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rdata;
            end else begin
                dmem_resp  = 1'b0;
                dmem_rdata = 32'h5555_5555;
            end
            #1;
            if (stall) begin
                stall_cycles++;
                checkOutput({tag, "_strobe"}, 32'({dmem_read, dmem_write}), 32'({rd, wr}));
                checkOutput({tag, "_address"}, dmem_address, exp_addr);
                checkOutput({tag, "_byte_enable"}, 32'(dmem_byte_enable), 32'(exp_be));
                checkOutput({tag, "_wdata"}, dmem_wdata & wmask, exp_wdata & wmask);
                checkOutput({tag, "_early_load_valid"}, 32'(load_valid), 32'd0);
            end else begin
                done       = 1'b1;
                done_cycle = c;
                checkOutput({tag, "_done_strobe"}, 32'({dmem_read, dmem_write}), 32'd0);
                checkOutput({tag, "_done_load_valid"}, 32'(load_valid), 32'(rd));
                checkOutput({tag, "_done_misaligned"}, 32'(misaligned), 32'd0);
                if (rd) begin
                    checkOutput({tag, "_load_data"}, load_data, exp_load);
                end
            end
        end
        dmem_resp = 1'b0;
        checkOutput({tag, "_done_cycle"}, 32'(done_cycle), 32'(resp_cycle + 1));
        checkOutput({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    endtask

    // Drop the request and confirm the unit is quiet on the following cycle.
    task automatic goIdle(input string tag);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput({tag, "_idle_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, "_idle_load_valid"}, 32'(load_valid), 32'd0);
        checkOutput({tag, "_idle_strobe"}, 32'({dmem_read, dmem_write}), 32'd0);
    endtask

    // An illegal request must pulse misaligned without stalling or touching memory.
    task automatic checkError(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a);
        @(negedge clk);
        applyStimulus(1'b1, rd, wr, f3, a, 32'h1234_5678);
        #1;
        checkOutput({tag, "_misaligned"}, 32'(misaligned), 32'd1);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
        goIdle(tag);
        checkOutput({tag, "_misaligned_cleared"}, 32'(misaligned), 32'd0);
    endtask

    // Directed scenario sequence.
    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_load_valid", 32'(load_valid), 32'd0);
        checkOutput("reset_misaligned", 32'(misaligned), 32'd0);
        checkOutput("reset_strobe", 32'({dmem_read, dmem_write}), 32'd0);
        checkOutput("reset_address", dmem_address, 32'h0);
        checkOutput("reset_wdata", dmem_wdata, 32'h0);
        checkOutput("reset_load_data", load_data, 32'h0);
        checkOutput("reset_byte_enable", 32'(dmem_byte_enable), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        doAccess("lw_100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 3,
                 32'h100, 4'b1111, 32'h0, 32'h0, 32'hDEAD_BEEF, 4);
        goIdle("lw_100");

        doAccess("lb_103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1,
                 32'h100, 4'b1111, 32'h0, 32'h0, 32'hFFFF_FF80, 2);
        goIdle("lb_103");
        doAccess("lbu_103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1,
                 32'h100, 4'b1111, 32'h0, 32'h0, 32'h0000_0080, 2);
        goIdle("lbu_103");
        doAccess("lh_102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 2,
                 32'h100, 4'b1111, 32'h0, 32'h0, 32'hFFFF_80FF, 3);
        goIdle("lh_102");
        doAccess("lhu_102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 1,
                 32'h100, 4'b1111, 32'h0, 32'h0, 32'h0000_80FF, 2);
        goIdle("lhu_102");
        doAccess("lb_101", 1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h1234_5678, 1,
                 32'h100, 4'b1111, 32'h0, 32'h0, 32'h0000_0056, 2);
        goIdle("lb_101");

        doAccess("sb_201", 1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0, 1,
                 32'h200, 4'b0010, 32'h0000_AB00, 32'h0000_FF00, 32'h0, 2);
        goIdle("sb_201");
        doAccess("sh_202", 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'h0, 1,
                 32'h200, 4'b1100, 32'h1234_0000, 32'hFFFF_0000, 32'h0, 2);
        goIdle("sh_202");

        checkError("lw_102", 1'b1, 1'b0, 3'b010, 32'h102);
        checkError("sh_203", 1'b0, 1'b1, 3'b001, 32'h203);
        checkError("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h100);
        checkError("store_f3_011", 1'b0, 1'b1, 3'b011, 32'h100);
        checkError("lhu_101", 1'b1, 1'b0, 3'b101, 32'h101);
        checkError("read_and_write", 1'b1, 1'b1, 3'b010, 32'h100);

        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h400, 32'h0);
        #1;
        checkOutput("non_mem_stall", 32'(stall), 32'd0);
        checkOutput("non_mem_misaligned", 32'(misaligned), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("non_mem_strobe", 32'({dmem_read, dmem_write}), 32'd0);

        doAccess("b2b_sw_300", 1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 1,
                 32'h300, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h0, 2);
        doAccess("b2b_lw_304", 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'h0123_4567, 1,
                 32'h304, 4'b1111, 32'h0, 32'h0, 32'h0123_4567, 2);
        goIdle("b2b");

        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        #1;
        checkOutput("rst_mid_c0_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("rst_mid_c1_strobe", 32'(dmem_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        #1;
        checkOutput("rst_mid_strobe", 32'({dmem_read, dmem_write}), 32'd0);
        checkOutput("rst_mid_stall", 32'(stall), 32'd0);
        checkOutput("rst_mid_load_valid", 32'(load_valid), 32'd0);
        checkOutput("rst_mid_address", dmem_address, 32'h0);
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        checkOutput("rst_late_resp_load_valid", 32'(load_valid), 32'd0);
        checkOutput("rst_late_resp_load_data", load_data, 32'h0);
        checkOutput("rst_late_resp_strobe", 32'({dmem_read, dmem_write}), 32'd0);
        doAccess("post_rst_lw_600", 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'hA5A5_0F0F, 1,
                 32'h600, 4'b1111, 32'h0, 32'h0, 32'hA5A5_0F0F, 2);
        goIdle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
